// File: rtl/alu_arbiter_pkg.sv
// Shared ALU opcode constants plus the arbiter's state and response types.
package alu_arbiter_pkg;

    localparam int unsigned OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] LL_SHIFT_OP = 4'd0;
    localparam logic [OPCODE_W-1:0] LR_SHIFT_OP = 4'd1;
    localparam logic [OPCODE_W-1:0] AR_SHIFT_OP = 4'd2;
    localparam logic [OPCODE_W-1:0] NOT_OP      = 4'd3;
    localparam logic [OPCODE_W-1:0] AND_OP      = 4'd4;
    localparam logic [OPCODE_W-1:0] OR_OP       = 4'd5;
    localparam logic [OPCODE_W-1:0] XOR_OP      = 4'd6;
    localparam logic [OPCODE_W-1:0] ADD_OP      = 4'd7;

    typedef enum logic {
        EMPTY,
        FULL
    } arb_state_t;

    // Result data is held beside this struct so WIDTH stays a free parameter.
    typedef struct packed {
        logic id;
        logic cout;
        logic overflow;
        logic negative;
        logic zero;
    } rsp_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: shifts by b, bitwise logic, and add with carry-in.
module alu
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [OPCODE_W-1:0] op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic                cin,
    output logic [WIDTH-1:0]    y,
    output logic                cout,
    output logic                overflow,
    output logic                negative,
    output logic                zero
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum      = '0;
        y        = '0;
        cout     = 1'b0;
        overflow = 1'b0;
        case (op)
            LL_SHIFT_OP: y = a << b;
            LR_SHIFT_OP: y = a >> b;
            AR_SHIFT_OP: y = $signed(a) >>> b;
            NOT_OP:      y = ~a;
            AND_OP:      y = a & b;
            OR_OP:       y = a | b;
            XOR_OP:      y = a ^ b;
            ADD_OP: begin
                sum      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
                y        = sum[WIDTH-1:0];
                cout     = sum[WIDTH];
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            default: y = '0;
        endcase
    end

    assign negative = y[WIDTH-1];
    assign zero     = (y == '0);

endmodule

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; on contention the port that did not win last is granted.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] grant,
    output logic       last_grant
);

    always_comb begin
        grant = '0;
        if (enable) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (|grant) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters with a one-entry response buffer
// and a per-requester carry flag for chained multi-word arithmetic.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned NREQ  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [OPCODE_W-1:0] req0_opcode,
    input  logic [WIDTH-1:0]    req0_a,
    input  logic [WIDTH-1:0]    req0_b,
    input  logic                req0_chain,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [OPCODE_W-1:0] req1_opcode,
    input  logic [WIDTH-1:0]    req1_a,
    input  logic [WIDTH-1:0]    req1_b,
    input  logic                req1_chain,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [WIDTH-1:0]    rsp_y,
    output logic                rsp_cout,
    output logic                rsp_overflow,
    output logic                rsp_negative,
    output logic                rsp_zero,
    output logic                busy
);

    arb_state_t          state, state_next;
    rsp_t                rsp_q;
    logic [WIDTH-1:0]    y_q;
    logic [NREQ-1:0]     carry_flag;
    logic [1:0]          grant;
    logic                last_grant, can_accept, enable, hs, gid, chain;
    logic [OPCODE_W-1:0] alu_op;
    logic [WIDTH-1:0]    alu_a, alu_b, alu_y;
    logic                alu_cin, alu_cout, alu_ov, alu_neg, alu_zero;

    assign can_accept = (state == EMPTY) || rsp_ready;
    assign enable     = can_accept && !reset;

    rr_arbiter2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .req        ({req1_valid, req0_valid}),
        .enable     (enable),
        .grant      (grant),
        .last_grant (last_grant)
    );

    always_comb begin
        hs     = |grant;
        gid    = grant[1];
        alu_op = gid ? req1_opcode : req0_opcode;
        alu_a  = gid ? req1_a : req0_a;
        alu_b  = gid ? req1_b : req0_b;
        chain  = gid ? req1_chain : req0_chain;
        alu_cin = chain & carry_flag[gid];
    end

    alu #(.WIDTH(WIDTH)) u_alu (
        .op       (alu_op),
        .a        (alu_a),
        .b        (alu_b),
        .cin      (alu_cin),
        .y        (alu_y),
        .cout     (alu_cout),
        .overflow (alu_ov),
        .negative (alu_neg),
        .zero     (alu_zero)
    );

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (hs) state_next = FULL;
            FULL:  if (rsp_ready && !hs) state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            rsp_q      <= '0;
            y_q        <= '0;
            carry_flag <= '0;
        end else begin
            state <= state_next;
            if (hs) begin
                rsp_q <= '{id: gid, cout: alu_cout, overflow: alu_ov,
                           negative: alu_neg, zero: alu_zero};
                y_q   <= alu_y;
                carry_flag[gid] <= alu_cout;
            end
        end
    end

    assign req0_ready   = grant[0];
    assign req1_ready   = grant[1];
    assign rsp_valid    = (state == FULL);
    assign busy         = rsp_valid;
    assign rsp_id       = rsp_q.id;
    assign rsp_y        = y_q;
    assign rsp_cout     = rsp_q.cout;
    assign rsp_overflow = rsp_q.overflow;
    assign rsp_negative = rsp_q.negative;
    assign rsp_zero     = rsp_q.zero;

    // Under contention the winner must be the port that lost the previous grant.
    assert property (@(posedge clk) disable iff (reset)
        (enable && req0_valid && req1_valid) |-> (grant[1] != last_grant));

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against an arithmetic reference model.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int unsigned W = 4;
    localparam int MOD  = 1 << W;
    localparam int HALF = 1 << (W - 1);

    logic clk = 1'b0;
    logic reset;
    logic req0_valid, req0_ready, req0_chain;
    logic req1_valid, req1_ready, req1_chain;
    logic [OPCODE_W-1:0] req0_opcode, req1_opcode;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b, rsp_y;
    logic rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_overflow, rsp_negative, rsp_zero, busy;

    int checks = 0;
    int failures = 0;

    int m_valid = 0, m_id = 0, m_y = 0, m_co = 0, m_ov = 0, m_neg = 0, m_zero = 0, m_last = 1;
    int m_carry [2] = '{0, 0};

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W), .NREQ(2)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_a(req0_a), .req0_b(req0_b), .req0_chain(req0_chain),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_a(req1_a), .req1_b(req1_b), .req1_chain(req1_chain),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
        .rsp_cout(rsp_cout), .rsp_overflow(rsp_overflow), .rsp_negative(rsp_negative),
        .rsp_zero(rsp_zero), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Operates on plain integers in the range 0..2^W-1.
    function automatic void alu_ref(input int op, input int a, input int b, input int cin,
                                    output int y, output int co, output int ov);
        int sa, sb, ss;
        y = 0; co = 0; ov = 0;
        sa = (a >= HALF) ? a - MOD : a;
        sb = (b >= HALF) ? b - MOD : b;
        case (op)
            int'(LL_SHIFT_OP): y = (b >= W) ? 0 : (a * (1 << b)) % MOD;
            int'(LR_SHIFT_OP): y = a / (1 << b);
            int'(AR_SHIFT_OP): y = (sa >>> b) & (MOD - 1);
            int'(NOT_OP):      y = MOD - 1 - a;
            int'(AND_OP):      y = a & b;
            int'(OR_OP):       y = a | b;
            int'(XOR_OP):      y = a ^ b;
            int'(ADD_OP): begin
                y  = (a + b + cin) % MOD;
                co = (a + b + cin >= MOD) ? 1 : 0;
                ss = sa + sb + cin;
                ov = (ss >= HALF || ss < -HALF) ? 1 : 0;
            end
            default: y = 0;
        endcase
    endfunction

    always @(negedge clk) begin : compare
        int g, y, co, ov;
        g = -1;
        if (!reset && (m_valid == 0 || rsp_ready)) begin
            if (req0_valid && req1_valid) g = (m_last == 1) ? 0 : 1;
            else if (req0_valid) g = 0;
            else if (req1_valid) g = 1;
        end
        check("req0_ready", 32'(req0_ready), 32'(g == 0));
        check("req1_ready", 32'(req1_ready), 32'(g == 1));
        check("rsp_valid", 32'(rsp_valid), m_valid);
        check("busy", 32'(busy), m_valid);
        if (m_valid != 0) begin
            check("rsp_id", 32'(rsp_id), m_id);
            check("rsp_y", 32'(rsp_y), m_y);
            check("rsp_cout", 32'(rsp_cout), m_co);
            check("rsp_overflow", 32'(rsp_overflow), m_ov);
            check("rsp_negative", 32'(rsp_negative), m_neg);
            check("rsp_zero", 32'(rsp_zero), m_zero);
        end
        if (reset) begin
            m_valid = 0; m_id = 0; m_y = 0; m_co = 0; m_ov = 0; m_neg = 0; m_zero = 0;
            m_carry[0] = 0; m_carry[1] = 0; m_last = 1;
        end else if (g >= 0) begin
            if (g == 0)
                alu_ref(int'(req0_opcode), int'(req0_a), int'(req0_b),
                        req0_chain ? m_carry[0] : 0, y, co, ov);
            else
                alu_ref(int'(req1_opcode), int'(req1_a), int'(req1_b),
                        req1_chain ? m_carry[1] : 0, y, co, ov);
            m_valid = 1; m_id = g; m_y = y; m_co = co; m_ov = ov;
            m_neg = (y >= HALF) ? 1 : 0;
            m_zero = (y == 0) ? 1 : 0;
            m_carry[g] = co;
            m_last = g;
        end else if (rsp_ready) begin
            m_valid = 0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic p0(input logic v, input logic [OPCODE_W-1:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic ch);
        req0_valid = v; req0_opcode = op; req0_a = a; req0_b = b; req0_chain = ch;
    endtask

    task automatic p1(input logic v, input logic [OPCODE_W-1:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic ch);
        req1_valid = v; req1_opcode = op; req1_a = a; req1_b = b; req1_chain = ch;
    endtask

    initial begin
        logic r0p, r1p;
        reset = 1'b1;
        rsp_ready = 1'b1;
        p0(1'b1, AND_OP, 4'b1111, 4'b0111, 1'b0);
        p1(1'b0, OR_OP, 4'b0000, 4'b0000, 1'b0);
        mid();
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        check("reset_ready0", 32'(req0_ready), 0);
        check("reset_rsp_y", 32'(rsp_y), 0);

        cyc(); reset = 1'b0;
        mid(); check("and_ready0", 32'(req0_ready), 1);
        cyc(); p0(1'b0, AND_OP, 4'b0000, 4'b0000, 1'b0);
        mid();
        check("and_valid", 32'(rsp_valid), 1);
        check("and_id", 32'(rsp_id), 0);
        check("and_y", 32'(rsp_y), 32'b0111);

        cyc(); p1(1'b1, AR_SHIFT_OP, 4'b1001, 4'b0001, 1'b0);
        mid(); check("ar_ready1", 32'(req1_ready), 1);
        cyc(); p1(1'b0, AR_SHIFT_OP, 4'b0000, 4'b0000, 1'b0);
        mid();
        check("ar_id", 32'(rsp_id), 1);
        check("ar_y", 32'(rsp_y), 32'b1100);
        check("ar_negative", 32'(rsp_negative), 1);

        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i < 4) begin
                p0(1'b1, XOR_OP, 4'b1100, 4'b1010, 1'b0);
                p1(1'b1, OR_OP, 4'b1010, 4'b0101, 1'b0);
            end else begin
                p0(1'b0, XOR_OP, 4'b0000, 4'b0000, 1'b0);
                p1(1'b0, OR_OP, 4'b0000, 4'b0000, 1'b0);
            end
            mid();
            if (i < 4) check("rr_ready0", 32'(req0_ready), 32'(i % 2 == 0));
            if (i > 0) begin
                check("rr_id", 32'(rsp_id), (i - 1) % 2);
                check("rr_y", 32'(rsp_y), ((i - 1) % 2 == 1) ? 32'b1111 : 32'b0110);
            end
        end

        cyc(); p0(1'b1, ADD_OP, 4'b1111, 4'b0001, 1'b0);
        mid();
        cyc(); p0(1'b0, ADD_OP, 4'b0000, 4'b0000, 1'b0); p1(1'b1, ADD_OP, 4'b0000, 4'b0000, 1'b1);
        mid();
        check("add_y", 32'(rsp_y), 0);
        check("add_cout", 32'(rsp_cout), 1);
        check("add_zero", 32'(rsp_zero), 1);
        cyc(); p1(1'b0, ADD_OP, 4'b0000, 4'b0000, 1'b0); p0(1'b1, ADD_OP, 4'b0000, 4'b0000, 1'b1);
        mid();
        check("chain1_id", 32'(rsp_id), 1);
        check("chain1_y", 32'(rsp_y), 0);
        cyc(); p0(1'b0, ADD_OP, 4'b0000, 4'b0000, 1'b0);
        mid();
        check("chain0_id", 32'(rsp_id), 0);
        check("chain0_y", 32'(rsp_y), 1);

        cyc(); p0(1'b1, LL_SHIFT_OP, 4'b0001, 4'b0001, 1'b0);
        mid();
        cyc(); p0(1'b0, LL_SHIFT_OP, 4'b0000, 4'b0000, 1'b0);
        p1(1'b1, OR_OP, 4'b0011, 4'b0100, 1'b0);
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mid();
            check("hold_valid", 32'(rsp_valid), 1);
            check("hold_y", 32'(rsp_y), 32'b0010);
            check("hold_ready0", 32'(req0_ready), 0);
            check("hold_ready1", 32'(req1_ready), 0);
            cyc();
        end
        rsp_ready = 1'b1;
        mid();
        check("drain_ready1", 32'(req1_ready), 1);
        check("drain_y", 32'(rsp_y), 32'b0010);
        cyc(); p1(1'b0, OR_OP, 4'b0000, 4'b0000, 1'b0);
        mid();
        check("reload_valid", 32'(rsp_valid), 1);
        check("reload_id", 32'(rsp_id), 1);
        check("reload_y", 32'(rsp_y), 7);

        cyc(); p0(1'b1, ADD_OP, 4'b1111, 4'b0001, 1'b0);
        mid();
        cyc(); p0(1'b0, ADD_OP, 4'b0000, 4'b0000, 1'b0); rsp_ready = 1'b0;
        mid(); check("pre_reset_cout", 32'(rsp_cout), 1);
        cyc(); reset = 1'b1;
        cyc();
        mid();
        check("midreset_valid", 32'(rsp_valid), 0);
        check("midreset_fields", 32'({rsp_id, rsp_y, rsp_cout, rsp_overflow, rsp_negative, rsp_zero}), 0);
        cyc(); reset = 1'b0; rsp_ready = 1'b1; p0(1'b1, ADD_OP, 4'b0000, 4'b0000, 1'b1);
        mid();
        cyc(); p0(1'b0, ADD_OP, 4'b0000, 4'b0000, 1'b0);
        mid();
        check("postreset_y", 32'(rsp_y), 0);
        check("postreset_cout", 32'(rsp_cout), 0);

        r0p = 1'b0;
        r1p = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            cyc();
            reset = ($urandom_range(0, 63) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (!(req0_valid && !r0p))
                p0($urandom_range(0, 9) < 7, OPCODE_W'($urandom_range(0, 8)), W'($urandom),
                   W'($urandom_range(0, 5)), 1'($urandom));
            if (!(req1_valid && !r1p))
                p1($urandom_range(0, 9) < 7, OPCODE_W'($urandom_range(0, 8)), W'($urandom),
                   W'($urandom_range(0, 5)), 1'($urandom));
            mid();
            r0p = req0_ready;
            r1p = req1_ready;
        end

        cyc();
        reset = 1'b0;
        p0(1'b0, AND_OP, 4'b0000, 4'b0000, 1'b0);
        p1(1'b0, AND_OP, 4'b0000, 4'b0000, 1'b0);
        mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
